// File: rtl/sumador_serie_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sumador_serie_if: start/busy/done handshake and operand bundle   |
// | for sumador_serie. ovf exists only with SUMADOR_SERIE_OVF_EN.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface sumador_serie_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             busy;
  logic             done;
`ifdef SUMADOR_SERIE_OVF_EN
  logic             ovf;

  modport master (output start, sub, a, b, ci, input s, co, busy, done, ovf);
  modport slave  (input start, sub, a, b, ci, output s, co, busy, done, ovf);
`else
  modport master (output start, sub, a, b, ci, input s, co, busy, done);
  modport slave  (input start, sub, a, b, ci, output s, co, busy, done);
`endif
endinterface
`default_nettype wire

// File: rtl/sumador_serie.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sumador_serie: sequential adder/subtractor, BPC bits per cycle,  |
// | LSB-first. Define SUMADOR_SERIE_OVF_EN for the signed ovf flag.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sumador_serie #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  wire logic      clk,
  input  wire logic      rst,
  sumador_serie_if.slave bus
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
`ifdef SUMADOR_SERIE_OVF_EN
  logic             ovf_q, ovf_d;
  logic             msb_cin;
`endif

  logic [BPC-1:0]   a_sl, b_sl, sum_sl;
  logic             c_out;
  logic [WIDTH-1:0] a_shift, b_shift, work_shift;

  // Operands drain out of the bottom; slice sums enter the working register from the top.
  generate
    if (BPC == WIDTH) begin : g_single
      assign a_shift    = '0;
      assign b_shift    = '0;
      assign work_shift = sum_sl;
    end else begin : g_multi
      assign a_shift    = a_q >> BPC;
      assign b_shift    = b_q >> BPC;
      assign work_shift = {sum_sl, work_q[WIDTH-1:BPC]};
    end
  endgenerate

  always_comb begin
    a_sl = a_q[BPC-1:0];
    b_sl = b_q[BPC-1:0];
    {c_out, sum_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{BPC{1'b0}}, carry_q};
  end

`ifdef SUMADOR_SERIE_OVF_EN
  // Carry into the MSB recovered from the MSB sum bit and its operand bits.
  assign msb_cin = sum_sl[BPC-1] ^ a_sl[BPC-1] ^ b_sl[BPC-1];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    s_d     = s_q;
    co_d    = co_q;
`ifdef SUMADOR_SERIE_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.ci;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_shift;
        b_d     = b_shift;
        work_d  = work_shift;
        carry_d = c_out;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
          s_d     = work_shift;
          co_d    = c_out;
`ifdef SUMADOR_SERIE_OVF_EN
          ovf_d   = msb_cin ^ c_out;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
`ifdef SUMADOR_SERIE_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      s_q     <= s_d;
      co_q    <= co_d;
`ifdef SUMADOR_SERIE_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
`ifdef SUMADOR_SERIE_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
`default_nettype wire
